// File: rtl/counter_sequencer.sv
// Programmable interval timer: prescaled 8-bit up-counter sequenced by an
// IDLE/RUN/DONE controller, with one-shot or auto-reload operation.
module counter_sequencer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  hold,
    input  logic [WIDTH-1:0]      terminal,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  auto_reload,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [1:0]            state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [PRESCALE_W-1:0] presc_cnt;
    logic [WIDTH-1:0]      lat_terminal;
    logic [PRESCALE_W-1:0] lat_prescale;
    logic                  lat_auto;
    logic                  tick;
    logic                  at_terminal;

    // A tick needs an un-held RUN cycle with the prescaler at its latched limit.
    assign tick        = (state == RUN) && !hold && (presc_cnt == lat_prescale);
    assign at_terminal = (count == lat_terminal);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            presc_cnt    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
            lat_terminal <= '0;
            lat_prescale <= '0;
            lat_auto     <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                count     <= '0;
                presc_cnt <= '0;
                busy      <= 1'b0;
            end else if (start && (state != RUN)) begin
                state        <= RUN;
                count        <= '0;
                presc_cnt    <= '0;
                busy         <= 1'b1;
                lat_terminal <= terminal;
                lat_prescale <= prescale;
                lat_auto     <= auto_reload;
            end else if (state == RUN) begin
                // A start during RUN only flags overrun; the run proceeds as normal.
                overrun <= start;
                if (tick) begin
                    presc_cnt <= '0;
                    if (!at_terminal) begin
                        count <= count + WIDTH'(1);
                    end else begin
                        done <= 1'b1;
                        if (lat_auto) begin
                            count <= '0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                end else if (!hold) begin
                    presc_cnt <= presc_cnt + PRESCALE_W'(1);
                end
            end
        end
    end

endmodule
